// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win the port,
// load results queue in an in-order FIFO and drain into idle cycles.
module regfile_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          write_data,
  output logic                     RegWrite,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic alu_win;
  logic non_empty;
  logic push;
  logic pop;

  logic [31:0] pending_c;

  // x0 writes never occupy the port or the queue
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  assign non_empty = (count != '0);
  assign mem_ready = (count != FULL);
  assign push      = mem_valid && mem_ready
                     && (mem_rd != 5'd0);
  assign pop       = !alu_win && non_empty;

  assign fifo_count = count;
  assign pending    = pending_c;

  // write-port register: ALU first, then FIFO head
  always_ff @(posedge clk) begin
    if (reset) begin
      rd         <= 5'd0;
      write_data <= '0;
      RegWrite   <= 1'b0;
    end else begin
      unique case (1'b1)
        alu_win: begin
          rd         <= alu_rd;
          write_data <= alu_data;
          RegWrite   <= 1'b1;
        end
        pop: begin
          rd         <= rd_q[rd_ptr];
          write_data <= data_q[rd_ptr];
          RegWrite   <= 1'b1;
        end
        default: begin
          RegWrite   <= 1'b0;
        end
      endcase
    end
  end

  // queue storage; no reset needed, validity comes from count
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      rd_q[wr_ptr]   <= mem_rd;
      data_q[wr_ptr] <= mem_data;
    end
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // occupancy; push+pop together leaves it unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // destination mask of every live queue entry
  always_comb begin
    logic [AW-1:0] offset;
    pending_c = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = i[AW-1:0] - rd_ptr;
      if ({1'b0, offset} < count)
        pending_c[rd_q[i]] = 1'b1;
    end
    pending_c[0] = 1'b0;
  end

endmodule
